muldiv_share_unit: RTL and testbench

//  Shared RV32M execute unit time-multiplexed between core 0 and core 1.

---
 rtl/muldiv_share_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_muldiv_share_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_share_unit.sv
// muldiv_share_unit
//   RV32M execute unit shared by two cores. A round-robin arbiter picks one
//   request while idle. A small FSM then runs a multi-cycle multiplier or a
//   radix-2 restoring divider and holds the result until the owning core
//   takes it.
//
// Ports (c = 0, 1)
//   clk, rst          rising-edge clock; synchronous active-low reset
//   req_valid_c       core c presents an M-op (funct3 in req_op_c)
//   req_ready_c       core c request accepted this cycle (at most one high)
//   req_a_c, req_b_c  rs1 / rs2 operands
//   req_tag_c         rd index, echoed on rsp_tag_c
//   flush_c           core c kills its pending or in-flight op
//   rsp_valid_c       result for core c available
//   rsp_ready_c       core c consumes the result
//   rsp_data_c        result value
//   rsp_tag_c         echoed tag
//   busy              unit is not idle
//   dbg_state         current FSM state, for checkers
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A requester holds valid and its payload stable until it sees
// ready. The unit holds rsp_valid and the response payload stable until it
// sees rsp_ready or the owner flushes.
module muldiv_share_unit #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_0,
  output logic            req_ready_0,
  input  logic [2:0]      req_op_0,
  input  logic [XLEN-1:0] req_a_0,
  input  logic [XLEN-1:0] req_b_0,
  input  logic [4:0]      req_tag_0,
  input  logic            flush_0,
  output logic            rsp_valid_0,
  input  logic            rsp_ready_0,
  output logic [XLEN-1:0] rsp_data_0,
  output logic [4:0]      rsp_tag_0,
  input  logic            req_valid_1,
  output logic            req_ready_1,
  input  logic [2:0]      req_op_1,
  input  logic [XLEN-1:0] req_a_1,
  input  logic [XLEN-1:0] req_b_1,
  input  logic [4:0]      req_tag_1,
  input  logic            flush_1,
  output logic            rsp_valid_1,
  input  logic            rsp_ready_1,
  output logic [XLEN-1:0] rsp_data_1,
  output logic [4:0]      rsp_tag_1,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CNT_W = $clog2(XLEN + MUL_LAT);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [CNT_W-1:0] cnt;
  logic            owner;
  logic            last_grant;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q;    // multiplicand, or dividend/quotient shift register
  logic [XLEN-1:0] b_q;    // multiplier, or divisor magnitude
  logic [XLEN-1:0] rem_q;  // partial remainder
  logic            neg_q;  // quotient needs negation at the end
  logic            neg_r;  // remainder needs negation at the end
  logic [4:0]      tag_q;
  logic [XLEN-1:0] data_q;

  // Arbitration
  logic            elig_0, elig_1, grant_any, grant, idle, accept;
  logic [2:0]      sel_op;
  logic [XLEN-1:0] sel_a, sel_b, a_mag, b_mag;
  logic [4:0]      sel_tag;
  logic            sel_signed, a_neg, b_neg, div_by_zero, div_ovf;

  assign idle      = (state == S_IDLE);
  assign elig_0    = req_valid_0 & ~flush_0;
  assign elig_1    = req_valid_1 & ~flush_1;
  assign grant_any = elig_0 | elig_1;
  // With both eligible, the core that was not served last goes next.
  assign grant     = (elig_0 & elig_1) ? ~last_grant : elig_1;
  assign req_ready_0 = idle & grant_any & ~grant;
  assign req_ready_1 = idle & grant_any & grant;
  assign accept    = idle & grant_any;

  assign sel_op  = grant ? req_op_1  : req_op_0;
  assign sel_a   = grant ? req_a_1   : req_a_0;
  assign sel_b   = grant ? req_b_1   : req_b_0;
  assign sel_tag = grant ? req_tag_1 : req_tag_0;

  // DIV and REM (funct3 bit0 clear) are the signed divides.
  assign sel_signed  = ~sel_op[0];
  assign a_neg       = sel_signed & sel_a[XLEN-1];
  assign b_neg       = sel_signed & sel_b[XLEN-1];
  assign a_mag       = a_neg ? (~sel_a + 1'b1) : sel_a;
  assign b_mag       = b_neg ? (~sel_b + 1'b1) : sel_b;
  assign div_by_zero = (sel_b == '0);
  assign div_ovf     = sel_signed & (sel_a == INT_MIN) & (sel_b == '1);

  // Multiplier: operands extended to 2*XLEN. The low 2*XLEN bits of the
  // unsigned product equal the two's complement product.
  logic              a_ext, b_ext;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN-1:0]   mul_res;

  assign a_ext   = ((op_q == 3'd1) | (op_q == 3'd2)) & a_q[XLEN-1];
  assign b_ext   = (op_q == 3'd1) & b_q[XLEN-1];
  assign mul_a   = {{XLEN{a_ext}}, a_q};
  assign mul_b   = {{XLEN{b_ext}}, b_q};
  assign prod    = mul_a * mul_b;
  assign mul_res = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // One restoring divide step on magnitudes
  logic [XLEN:0]   div_sh, div_diff;
  logic            take;
  logic [XLEN-1:0] rem_nxt, quot_nxt, div_res;

  assign div_sh   = {rem_q, a_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, b_q};
  assign take     = ~div_diff[XLEN];
  assign rem_nxt  = take ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
  assign quot_nxt = {a_q[XLEN-2:0], take};
  assign div_res  = op_q[1] ? (neg_r ? (~rem_nxt + 1'b1) : rem_nxt)
                            : (neg_q ? (~quot_nxt + 1'b1) : quot_nxt);

  logic flush_own, rsp_ready_own;
  assign flush_own     = owner ? flush_1 : flush_0;
  assign rsp_ready_own = owner ? rsp_ready_1 : rsp_ready_0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      tag_q      <= '0;
      data_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            owner      <= grant;
            last_grant <= grant;
            op_q       <= sel_op;
            tag_q      <= sel_tag;
            if (!sel_op[2]) begin
              state <= S_MUL;
              cnt   <= CNT_W'(MUL_LAT - 1);
              a_q   <= sel_a;
              b_q   <= sel_b;
            end else if (div_by_zero) begin
              state  <= S_DONE;
              data_q <= sel_op[1] ? sel_a : '1;
            end else if (div_ovf) begin
              state  <= S_DONE;
              data_q <= sel_op[1] ? '0 : INT_MIN;
            end else begin
              state <= S_DIV;
              cnt   <= CNT_W'(XLEN - 1);
              a_q   <= a_mag;
              b_q   <= b_mag;
              rem_q <= '0;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
            end
          end
        end
        S_MUL: begin
          if (flush_own) begin
            state <= S_IDLE;
          end else if (cnt == '0) begin
            state  <= S_DONE;
            data_q <= mul_res;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DIV: begin
          if (flush_own) begin
            state <= S_IDLE;
          end else begin
            a_q   <= quot_nxt;
            rem_q <= rem_nxt;
            if (cnt == '0) begin
              state  <= S_DONE;
              data_q <= div_res;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          if (flush_own || rsp_ready_own) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid_0 = (state == S_DONE) & ~owner;
  assign rsp_valid_1 = (state == S_DONE) & owner;
  assign rsp_data_0  = data_q;
  assign rsp_data_1  = data_q;
  assign rsp_tag_0   = tag_q;
  assign rsp_tag_1   = tag_q;
  assign busy        = ~idle;
  assign dbg_state   = state;

endmodule

// File: tb/tb_muldiv_share_unit.sv
// tb_muldiv_share_unit
//   Directed bench for muldiv_share_unit: clock/reset, driver tasks, a
//   scoreboard queue of {core, tag, data} filled when a request is issued and
//   drained when a response appears, and a final report line.
module tb_muldiv_share_unit;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = XLEN;  // edges after accept until rsp_valid

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  flush = 2'b00;
  logic [1:0]  rsp_ready = 2'b11;
  logic [2:0]  req_op [2];
  logic [31:0] req_a [2];
  logic [31:0] req_b [2];
  logic [4:0]  req_tag [2];
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data [2];
  logic [4:0]  rsp_tag [2];
  logic        busy;
  logic [1:0]  dbg_state;

  logic [37:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  muldiv_share_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid[0]), .req_ready_0(req_ready[0]), .req_op_0(req_op[0]),
    .req_a_0(req_a[0]), .req_b_0(req_b[0]), .req_tag_0(req_tag[0]), .flush_0(flush[0]),
    .rsp_valid_0(rsp_valid[0]), .rsp_ready_0(rsp_ready[0]), .rsp_data_0(rsp_data[0]),
    .rsp_tag_0(rsp_tag[0]),
    .req_valid_1(req_valid[1]), .req_ready_1(req_ready[1]), .req_op_1(req_op[1]),
    .req_a_1(req_a[1]), .req_b_1(req_b[1]), .req_tag_1(req_tag[1]), .flush_1(flush[1]),
    .rsp_valid_1(rsp_valid[1]), .rsp_ready_1(rsp_ready[1]), .rsp_data_1(rsp_data[1]),
    .rsp_tag_1(rsp_tag[1]),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model of the RV32M result, written with native 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, p;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Drive one request on core c, wait (bounded) for ready, optionally record the expectation.
  task automatic issue(input int c, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag, input bit push);
    int n;
    @(negedge clk);
    req_op[c] = op; req_a[c] = a; req_b[c] = b; req_tag[c] = tag;
    req_valid[c] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[c] && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("req_ready", req_ready[c], 1'b1);
    if (push) exp_q.push_back({c[0], tag, model(op, a, b)});
    @(posedge clk); #1;
    req_valid[c] = 1'b0;
  endtask

  // Wait for a response after an accept edge, count edges, compare with the scoreboard.
  task automatic wait_rsp(input int exp_lat, input int hold);
    int lat;
    int c;
    logic [37:0] exp_e;
    exp_e = '0;
    lat = 0;
    @(negedge clk);
    while (rsp_valid == 2'b00 && lat < 100) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    chk("rsp_seen", rsp_valid != 2'b00, 1'b1);
    if (rsp_valid != 2'b00) begin
      c = rsp_valid[1] ? 1 : 0;
      chk("rsp_latency", lat, exp_lat);
      chk("rsp_onehot", rsp_valid, (c == 1) ? 2'b10 : 2'b01);
      chk("sb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        chk("rsp_core", c, exp_e[37]);
        chk("rsp_tag", rsp_tag[c], exp_e[36:32]);
        chk("rsp_data", rsp_data[c], exp_e[31:0]);
      end
      if (hold > 0) begin
        repeat (hold) @(negedge clk);
        chk("rsp_hold_valid", rsp_valid[c], 1'b1);
        chk("rsp_hold_data", rsp_data[c], exp_e[31:0]);
        rsp_ready[c] = 1'b1;
      end
      @(posedge clk); #1;
      chk("idle_after_rsp", busy, 1'b0);
    end
  endtask

  initial begin
    int g;
    for (int i = 0; i < 2; i++) begin
      req_op[i] = '0; req_a[i] = '0; req_b[i] = '0; req_tag[i] = '0;
    end

    // Reset with both cores already requesting
    req_op[0] = 3'd0; req_a[0] = 32'd3;          req_b[0] = 32'd5; req_tag[0] = 5'd1;
    req_op[1] = 3'd3; req_a[1] = 32'hFFFF_FFFF;  req_b[1] = 32'd2; req_tag[1] = 5'd2;
    req_valid = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 2'b00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_data", rsp_data[0], 32'd0);
    chk("reset_tag", rsp_tag[1], 5'd0);
    rst = 1'b1;

    // T5: continuous requests from both cores alternate 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      #1;
      g = i % 2;
      chk("t5_grant", req_ready, (g == 1) ? 2'b10 : 2'b01);
      exp_q.push_back({g[0], req_tag[g], model(req_op[g], req_a[g], req_b[g])});
      @(posedge clk);
      wait_rsp(MUL_LAT, 0);
    end
    req_valid = 2'b00;

    // T1: MUL on core 0, with core 1 flushing (non-owner flush is ignored)
    flush[1] = 1'b1;
    issue(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1);
    wait_rsp(MUL_LAT, 0);
    flush[1] = 1'b0;

    // T2: high-half multiplies
    issue(1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b1);
    wait_rsp(MUL_LAT, 0);
    issue(1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b1);
    wait_rsp(MUL_LAT, 0);
    issue(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b1);
    wait_rsp(MUL_LAT, 0);

    // T3: signed divide and remainder; the remainder is held unconsumed for 2 cycles
    issue(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b1);
    wait_rsp(DIV_LAT, 0);
    rsp_ready[0] = 1'b0;
    issue(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, 1'b1);
    wait_rsp(DIV_LAT, 2);
    issue(1, 3'd4, 32'h8000_0000, 32'd3, 5'd16, 1'b1);
    wait_rsp(DIV_LAT, 0);

    // T4: special-case divides
    issue(1, 3'd5, 32'd9, 32'd0, 5'd12, 1'b1);
    wait_rsp(0, 0);
    issue(1, 3'd6, 32'd9, 32'd0, 5'd13, 1'b1);
    wait_rsp(0, 0);
    issue(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1);
    wait_rsp(0, 0);
    issue(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b1);
    wait_rsp(0, 0);

    // Flush while idle masks the request
    @(negedge clk);
    flush[0] = 1'b1; req_valid[0] = 1'b1;
    #1;
    chk("idle_flush_mask", req_ready[0], 1'b0);
    @(posedge clk); #1;
    chk("idle_flush_no_accept", busy, 1'b0);
    req_valid[0] = 1'b0; flush[0] = 1'b0;

    // T6a: flush core 0 divide in its 10th cycle; pending core 1 goes next
    issue(0, 3'd4, 32'd1000, 32'd3, 5'd17, 1'b0);
    @(negedge clk);
    req_op[1] = 3'd7; req_a[1] = 32'd100; req_b[1] = 32'd7; req_tag[1] = 5'd18;
    req_valid[1] = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    flush[0] = 1'b1;
    #1;
    chk("flush_pre_busy", busy, 1'b1);
    chk("flush_pre_no_grant", req_ready[1], 1'b0);
    @(posedge clk); #1;
    flush[0] = 1'b0;
    chk("flush_busy_drop", busy, 1'b0);
    chk("flush_no_rsp", rsp_valid, 2'b00);
    chk("flush_pending_granted", req_ready[1], 1'b1);
    exp_q.push_back({1'b1, 5'd18, model(3'd7, 32'd100, 32'd7)});
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_rsp(DIV_LAT, 0);

    // T6b: reset in the middle of a divide
    issue(0, 3'd5, 32'd12345, 32'd7, 5'd19, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rsp_valid", rsp_valid, 2'b00);
    chk("midrst_data", rsp_data[0], 32'd0);
    chk("midrst_tag", rsp_tag[0], 5'd0);
    @(negedge clk);
    rst = 1'b1;

    // Unit works again after reset
    issue(1, 3'd5, 32'd12345, 32'd7, 5'd20, 1'b1);
    wait_rsp(DIV_LAT, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
